// File: rtl/lvds_tx_packer.sv
// lvds_tx_packer: frames the host TX byte stream, checks sync markers and
// repacks each good 4-byte frame into the 32-bit LVDS TX FIFO word.
//
// Ports:
//   i_sys_clk, i_reset      system clock, synchronous active-high reset
//   i_enable                packing enable; low drops any partial frame
//   i_clear_err             pulse, zeroes o_sync_err_count
//   i_data, i_valid,        host byte stream; byte taken on
//   o_ready                 i_valid & o_ready
//   o_fifo_data,            repacked word {3'b0,I[12:0],3'b0,Q[12:0]}
//   o_fifo_write,           and its write strobe into the TX FIFO
//   i_fifo_full
//   o_locked                frame sync acquired
//   o_sync_err_count        saturating sync-loss counter
module lvds_tx_packer (
  input  logic        i_sys_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_clear_err,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [31:0] o_fifo_data,
  output logic        o_fifo_write,
  input  logic        i_fifo_full,
  output logic        o_locked,
  output logic [7:0]  o_sync_err_count
);

  typedef enum logic [1:0] {
    HUNT,
    B1,
    B2,
    B3
  } state_t;

  state_t state;
  state_t state_nx;

  // Captured frame fields: I[12:7], I[6:0], Q[12:7]
  logic [5:0] i_hi;
  logic [6:0] i_lo;
  logic [5:0] q_hi;

  logic pending;
  logic accept;
  logic is_b0;
  logic is_b2;

  logic ld_ihi;
  logic ld_ilo;
  logic ld_qhi;
  logic ld_word;
  logic sync_err;

  assign is_b0 = (i_data[7:6] == 2'b10);
  assign is_b2 = (i_data[7:6] == 2'b01);

  // Byte3 must wait until the held word has left; earlier bytes
  // of the next frame may flow in behind it.
  assign o_ready = i_enable & ~(pending & (state == B3));
  assign accept  = i_valid & o_ready;

  assign o_fifo_write = pending & ~i_fifo_full;

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state <= HUNT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ld_ihi   = 1'b0;
    ld_ilo   = 1'b0;
    ld_qhi   = 1'b0;
    ld_word  = 1'b0;
    sync_err = 1'b0;
    if (!i_enable) begin
      state_nx = HUNT;
    end else if (accept) begin
      unique case (state)
        HUNT: begin
          if (is_b0) begin
            ld_ihi   = 1'b1;
            state_nx = B1;
          end
        end
        B1: begin
          ld_ilo   = 1'b1;
          state_nx = B2;
        end
        B2: begin
          if (is_b2) begin
            ld_qhi   = 1'b1;
            state_nx = B3;
          end else if (is_b0) begin
            // Resync: the offending byte starts a new frame
            sync_err = 1'b1;
            ld_ihi   = 1'b1;
            state_nx = B1;
          end else begin
            sync_err = 1'b1;
            state_nx = HUNT;
          end
        end
        B3: begin
          ld_word  = 1'b1;
          state_nx = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      i_hi <= '0;
      i_lo <= '0;
      q_hi <= '0;
    end else begin
      if (ld_ihi) begin
        i_hi <= i_data[5:0];
      end
      if (ld_ilo) begin
        i_lo <= i_data[7:1];
      end
      if (ld_qhi) begin
        q_hi <= i_data[5:0];
      end
    end
  end

  // A new load wins over a same-cycle write-out of the old word.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      pending     <= 1'b0;
      o_fifo_data <= '0;
    end else if (ld_word) begin
      pending     <= 1'b1;
      o_fifo_data <= {3'b000, i_hi, i_lo,
                      3'b000, q_hi, i_data[7:1]};
    end else if (o_fifo_write) begin
      pending     <= 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      o_locked <= 1'b0;
    end else if (sync_err) begin
      o_locked <= 1'b0;
    end else if (ld_word) begin
      o_locked <= 1'b1;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      o_sync_err_count <= '0;
    end else if (i_clear_err) begin
      o_sync_err_count <= '0;
    end else if (sync_err && (o_sync_err_count != 8'hFF)) begin
      o_sync_err_count <= o_sync_err_count + 8'd1;
    end
  end

endmodule
